// File: rtl/spmm_pass_ctrl.sv
// Pass sequencer for the sparse-input x dense-weight datapath: loads one weight
// column pair, streams the nonzero list through a 1-deep skid, repeats per pair.
module spmm_pass_ctrl #(
  parameter int DATA_BITS = 16,
  parameter int NNZ_BITS  = 10,
  parameter int W_ROWS    = 32,
  parameter int W_COLS    = 8,
  parameter int ROW_BITS  = 7,
  parameter int COL_BITS  = 5,
  parameter int WCOL_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [NNZ_BITS-1:0]    i_nnz_cnt,
  output logic                   o_in_ren,
  output logic [NNZ_BITS-1:0]    o_in_addr,
  input  logic [DATA_BITS-1:0]   i_in_data,
  input  logic [ROW_BITS-1:0]    i_in_row,
  input  logic [COL_BITS-1:0]    i_in_col,
  output logic                   o_w_ren,
  output logic [WCOL_BITS+4:0]   o_w_addr,
  input  logic [DATA_BITS-1:0]   i_w_data,
  output logic                   o_w_valid,
  output logic [DATA_BITS-1:0]   o_w_data,
  output logic [WCOL_BITS-1:0]   o_w_col_idx,
  output logic                   o_rdy,
  output logic [DATA_BITS-1:0]   o_data,
  output logic [ROW_BITS-1:0]    o_row_ptr,
  output logic [COL_BITS-1:0]    o_col_idx,
  input  logic                   i_sched_busy,
  output logic                   o_done,
  output logic                   o_busy,
  output logic                   o_finish
);

  localparam int PAIR_BITS = WCOL_BITS - 1;
  localparam int WCNT_BITS = 6;
  localparam logic [PAIR_BITS-1:0] LAST_PAIR = PAIR_BITS'(W_COLS / 2 - 1);
  localparam logic [WCNT_BITS-1:0] LAST_BEAT = WCNT_BITS'(2 * W_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_STREAM, S_DRAIN, S_NEXT, S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [NNZ_BITS-1:0]  nnz;
  logic [NNZ_BITS-1:0]  rd_cnt;
  logic [NNZ_BITS-1:0]  acc_cnt;
  logic [PAIR_BITS-1:0] pair;
  logic [WCNT_BITS-1:0] wcnt;
  logic [WCOL_BITS-1:0] w_col;

  logic                 skid_vld_p1;
  logic [DATA_BITS-1:0] skid_data_p1;
  logic [ROW_BITS-1:0]  skid_row_p1;
  logic [COL_BITS-1:0]  skid_col_p1;

  logic in_ren;
  logic accept;
  logic last_acc;

  always_comb begin
    w_col    = {pair, wcnt[WCNT_BITS-1]};
    accept   = o_rdy && !i_sched_busy;
    last_acc = accept && (acc_cnt == nnz - NNZ_BITS'(1));
    in_ren   = (state == S_STREAM) && !skid_vld_p1 && (rd_cnt != nnz) && !i_sched_busy;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_start) state_nxt = S_WLOAD;
      S_WLOAD:  if (wcnt == LAST_BEAT) state_nxt = (nnz == '0) ? S_DRAIN : S_STREAM;
      S_STREAM: if (last_acc) state_nxt = S_DRAIN;
      S_DRAIN:  if (!i_sched_busy) state_nxt = S_NEXT;
      S_NEXT:   state_nxt = (pair == LAST_PAIR) ? S_FINISH : S_WLOAD;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ren  = in_ren;
    o_in_addr = in_ren ? rd_cnt : '0;
    o_w_ren   = (state == S_WLOAD);
    o_w_addr  = o_w_ren ? {w_col, wcnt[4:0]} : '0;
    o_done    = (state == S_DRAIN) && !i_sched_busy;
    o_finish  = (state == S_FINISH);
    o_busy    = (state != S_IDLE);
  end

  // control: state, pass bookkeeping and address counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      nnz     <= '0;
      pair    <= '0;
      wcnt    <= '0;
      rd_cnt  <= '0;
      acc_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && i_start) begin
        nnz  <= i_nnz_cnt;
        pair <= '0;
      end
      if (state == S_NEXT) pair <= pair + PAIR_BITS'(1);
      wcnt <= (state == S_WLOAD) ? wcnt + WCNT_BITS'(1) : '0;
      if (state == S_WLOAD) begin
        rd_cnt  <= '0;
        acc_cnt <= '0;
      end else begin
        if (in_ren) rd_cnt  <= rd_cnt + NNZ_BITS'(1);
        if (accept) acc_cnt <= acc_cnt + NNZ_BITS'(1);
      end
    end
  end

  // stage p1: weight word registered one cycle after its read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_w_valid   <= 1'b0;
      o_w_data    <= '0;
      o_w_col_idx <= '0;
    end else begin
      o_w_valid <= o_w_ren;
      if (o_w_ren) begin
        o_w_data    <= i_w_data;
        o_w_col_idx <= w_col;
      end
    end
  end

  // stage p1: entry output register with skid behind it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_rdy        <= 1'b0;
      o_data       <= '0;
      o_row_ptr    <= '0;
      o_col_idx    <= '0;
      skid_vld_p1  <= 1'b0;
      skid_data_p1 <= '0;
      skid_row_p1  <= '0;
      skid_col_p1  <= '0;
    end else if (state != S_STREAM) begin
      o_rdy       <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (in_ren) begin
      if (!o_rdy || accept) begin
        o_rdy     <= 1'b1;
        o_data    <= i_in_data;
        o_row_ptr <= i_in_row;
        o_col_idx <= i_in_col;
      end else begin
        skid_vld_p1  <= 1'b1;
        skid_data_p1 <= i_in_data;
        skid_row_p1  <= i_in_row;
        skid_col_p1  <= i_in_col;
      end
    end else if (accept) begin
      if (skid_vld_p1) begin
        o_data      <= skid_data_p1;
        o_row_ptr   <= skid_row_p1;
        o_col_idx   <= skid_col_p1;
        skid_vld_p1 <= 1'b0;
      end else begin
        o_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spmm_pass_ctrl.sv
// Bench for spmm_pass_ctrl: table of run scenarios against an array/queue
// reference of the expected weight and entry streams, plus reset corner cases.
module tb_spmm_pass_ctrl;

  localparam int DATA_BITS = 16;
  localparam int NNZ_BITS  = 10;
  localparam int W_ROWS    = 32;
  localparam int W_COLS    = 8;
  localparam int ROW_BITS  = 7;
  localparam int COL_BITS  = 5;
  localparam int WCOL_BITS = 3;
  localparam int PASSES    = W_COLS / 2;
  localparam int W_WORDS   = W_ROWS * W_COLS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 i_start = 1'b0;
  logic [NNZ_BITS-1:0]  i_nnz_cnt = '0;
  logic                 o_in_ren;
  logic [NNZ_BITS-1:0]  o_in_addr;
  logic [DATA_BITS-1:0] i_in_data;
  logic [ROW_BITS-1:0]  i_in_row;
  logic [COL_BITS-1:0]  i_in_col;
  logic                 o_w_ren;
  logic [WCOL_BITS+4:0] o_w_addr;
  logic [DATA_BITS-1:0] i_w_data;
  logic                 o_w_valid;
  logic [DATA_BITS-1:0] o_w_data;
  logic [WCOL_BITS-1:0] o_w_col_idx;
  logic                 o_rdy;
  logic [DATA_BITS-1:0] o_data;
  logic [ROW_BITS-1:0]  o_row_ptr;
  logic [COL_BITS-1:0]  o_col_idx;
  logic                 i_sched_busy = 1'b0;
  logic                 o_done;
  logic                 o_busy;
  logic                 o_finish;

  always #5 clk = ~clk;

  logic [DATA_BITS-1:0] wmem    [W_WORDS];
  logic [DATA_BITS-1:0] in_data [1024];
  logic [ROW_BITS-1:0]  in_row  [1024];
  logic [COL_BITS-1:0]  in_col  [1024];

  // read ports deliver the addressed word for capture at the edge closing the read cycle
  assign i_w_data  = o_w_ren  ? wmem[o_w_addr]     : 16'hA5A5;
  assign i_in_data = o_in_ren ? in_data[o_in_addr] : 16'h5A5A;
  assign i_in_row  = o_in_ren ? in_row[o_in_addr]  : 7'h55;
  assign i_in_col  = o_in_ren ? in_col[o_in_addr]  : 5'h0A;

  spmm_pass_ctrl #(
    .DATA_BITS(DATA_BITS), .NNZ_BITS(NNZ_BITS), .W_ROWS(W_ROWS), .W_COLS(W_COLS),
    .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .WCOL_BITS(WCOL_BITS)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_nnz_cnt(i_nnz_cnt),
    .o_in_ren(o_in_ren), .o_in_addr(o_in_addr), .i_in_data(i_in_data),
    .i_in_row(i_in_row), .i_in_col(i_in_col), .o_w_ren(o_w_ren), .o_w_addr(o_w_addr),
    .i_w_data(i_w_data), .o_w_valid(o_w_valid), .o_w_data(o_w_data),
    .o_w_col_idx(o_w_col_idx), .o_rdy(o_rdy), .o_data(o_data), .o_row_ptr(o_row_ptr),
    .o_col_idx(o_col_idx), .i_sched_busy(i_sched_busy), .o_done(o_done),
    .o_busy(o_busy), .o_finish(o_finish)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ent(input int k);
    return (int'(in_row[k]) << 21) | (int'(in_col[k]) << 16) | int'(in_data[k]);
  endfunction

  // observation state, cleared when clr_gen is bumped
  int clr_gen = 0, clr_seen = 0;
  int first_wren, first_wval, first_inren, first_rdy;
  int cyc, wrun, done_cnt, fin_cnt, done_long, stab_err, ovl_err, addr_err, waddr_err;
  int rdy_cycles, addr_exp, w_idx;
  int wq[$], eq[$], runs[$], done_pos[$];
  logic prev_rdy, prev_busy, prev_done;
  logic [DATA_BITS-1:0] pd;
  logic [ROW_BITS-1:0]  pr;
  logic [COL_BITS-1:0]  pc;

  always @(negedge clk) begin
    if (clr_gen != clr_seen) begin
      first_wren = -1; first_wval = -1; first_inren = -1; first_rdy = -1;
      cyc = 0; wrun = 0; done_cnt = 0; fin_cnt = 0; done_long = 0; stab_err = 0;
      ovl_err = 0; addr_err = 0; waddr_err = 0; rdy_cycles = 0; addr_exp = 0; w_idx = 0;
      wq.delete(); eq.delete(); runs.delete(); done_pos.delete();
      prev_rdy = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
      clr_seen = clr_gen;
    end
    cyc++;
    if (o_w_ren && first_wren < 0)   first_wren = cyc;
    if (o_w_valid && first_wval < 0) first_wval = cyc;
    if (o_in_ren && first_inren < 0) first_inren = cyc;
    if (o_rdy && first_rdy < 0)      first_rdy = cyc;
    if (o_in_ren && o_w_ren) ovl_err++;
    if (o_w_ren) begin
      if (o_w_addr != 8'(w_idx)) waddr_err++;
      w_idx++;
    end
    if (o_in_ren) begin
      if (int'(o_in_addr) != addr_exp) addr_err++;
      addr_exp++;
    end
    if (o_w_valid) begin
      wq.push_back((int'(o_w_col_idx) << 16) | int'(o_w_data));
      wrun++;
    end else if (wrun > 0) begin
      runs.push_back(wrun);
      wrun = 0;
    end
    if (prev_rdy && prev_busy && (!o_rdy || o_data != pd || o_row_ptr != pr || o_col_idx != pc))
      stab_err++;
    if (o_rdy) rdy_cycles++;
    if (o_rdy && !i_sched_busy)
      eq.push_back((int'(o_row_ptr) << 21) | (int'(o_col_idx) << 16) | int'(o_data));
    if (o_done) begin
      done_cnt++;
      done_pos.push_back(eq.size());
      addr_exp = 0;
      if (prev_done) done_long++;
    end
    if (o_finish) fin_cnt++;
    prev_rdy = o_rdy; prev_busy = i_sched_busy; prev_done = o_done;
    pd = o_data; pr = o_row_ptr; pc = o_col_idx;
  end

  task automatic run_case(input int nnz, input int pct, input int mode,
                          input int exp_done, input int exp_fin);
    int held, hold_left, poked, w_bad, e_bad, p_bad, r_bad;
    held = 0; hold_left = 0; poked = 0;
    clr_gen++;
    i_sched_busy = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b1; i_nnz_cnt = NNZ_BITS'(nnz);
    @(posedge clk); #1;
    i_start = 1'b0; i_nnz_cnt = NNZ_BITS'($urandom);
    for (int k = 0; k < 20000; k++) begin
      if (fin_cnt > 0) break;
      i_start = 1'b0;
      if (mode == 1 && held == 0 && o_rdy && o_data == in_data[1]) begin
        held = 1; hold_left = 3;
      end
      if (hold_left > 0) begin
        i_sched_busy = 1'b1;
        hold_left--;
        chk("hold_rdy", o_rdy, 1);
        chk("hold_data", o_data, in_data[1]);
      end else begin
        i_sched_busy = ($urandom_range(0, 99) < pct);
      end
      if (mode == 2 && poked == 0 && o_rdy) begin
        i_start = 1'b1; i_nnz_cnt = NNZ_BITS'(nnz + 3); poked = 1;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0; i_sched_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_cnt", done_cnt, exp_done);
    chk("finish_cnt", fin_cnt, exp_fin);
    chk("busy_after", o_busy, 0);
    chk("w_beats", wq.size(), W_WORDS);
    w_bad = 0;
    for (int i = 0; i < wq.size() && i < W_WORDS; i++)
      if (wq[i] != (((i / W_ROWS) << 16) | int'(wmem[i]))) w_bad++;
    chk("w_stream", w_bad, 0);
    chk("entries", eq.size(), PASSES * nnz);
    e_bad = 0;
    for (int i = 0; i < eq.size() && i < PASSES * nnz; i++)
      if (eq[i] != ent(i % nnz)) e_bad++;
    chk("entry_order", e_bad, 0);
    p_bad = 0;
    for (int p = 0; p < done_pos.size(); p++)
      if (done_pos[p] != (p + 1) * nnz) p_bad++;
    chk("done_after_last", p_bad, 0);
    chk("w_runs", runs.size(), PASSES);
    r_bad = 0;
    foreach (runs[i]) if (runs[i] != 2 * W_ROWS) r_bad++;
    chk("w_gapfree", r_bad, 0);
    chk("w_latency", first_wval - first_wren, 1);
    if (nnz > 0) chk("rdy_latency", first_rdy - first_inren, 1);
    if (nnz == 0 || (pct == 0 && mode != 1)) chk("rdy_cycles", rdy_cycles, PASSES * nnz);
    if (mode == 1) chk("hold_seen", held, 1);
    chk("stable_err", stab_err, 0);
    chk("ren_overlap", ovl_err, 0);
    chk("in_addr_err", addr_err, 0);
    chk("w_addr_err", waddr_err, 0);
    chk("done_width", done_long, 0);
  endtask

  typedef struct {
    int nnz;
    int pct;
    int mode;
    int exp_done;
    int exp_fin;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [9:0] ii;
    for (int i = 0; i < W_WORDS; i++) wmem[i] = 16'($urandom);
    for (int i = 0; i < 1024; i++) begin
      ii = 10'(i);
      in_data[i] = {ii, 6'($urandom)};
      in_row[i]  = 7'($urandom);
      in_col[i]  = 5'($urandom);
    end
    tbl[0] = '{5, 0, 0, PASSES, 1};
    tbl[1] = '{4, 0, 1, PASSES, 1};
    tbl[2] = '{0, 40, 0, PASSES, 1};
    tbl[3] = '{6, 0, 2, PASSES, 1};
    tbl[4] = '{13, 60, 0, PASSES, 1};
    tbl[5] = '{int'($urandom_range(1, 40)), 35, 0, PASSES, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {o_in_ren, o_in_addr, o_w_ren, o_w_addr, o_w_valid, o_w_col_idx,
                       o_rdy, o_done, o_busy, o_finish}, 0);
    chk("reset_data", {o_w_data, o_data, o_row_ptr, o_col_idx}, 0);
    rst = 1'b1;

    for (int t = 0; t < 6; t++)
      run_case(tbl[t].nnz, tbl[t].pct, tbl[t].mode, tbl[t].exp_done, tbl[t].exp_fin);

    // abort during the second weight load, then restart from column 0
    clr_gen++;
    @(posedge clk); #1;
    i_start = 1'b1; i_nnz_cnt = 10'd3;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (done_cnt == 1 && o_w_ren) break;
      @(posedge clk); #1;
    end
    chk("abort_reached_pass2", done_cnt, 1);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_ctrl", {o_in_ren, o_in_addr, o_w_ren, o_w_addr, o_w_valid, o_w_col_idx,
                       o_rdy, o_done, o_busy, o_finish}, 0);
    chk("abort_data", {o_w_data, o_data, o_row_ptr, o_col_idx}, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("abort_no_done", done_cnt, 1);
    chk("abort_no_finish", fin_cnt, 0);
    chk("abort_idle", o_busy, 0);
    rst = 1'b1;
    run_case(2, 0, 0, PASSES, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
